// File: rtl/img2col_map_ctrl.sv
// img2col PU write-address sequencer: BUFFER preloads KERNEL rows, WORK streams NUM_ROUNDS rows.
// Each address step is gated by advance; abort returns to IDLE without a done pulse.
module img2col_map_ctrl #(
    parameter int KERNEL     = 5,
    parameter int NUM_PU     = 28,
    parameter int NUM_ROUNDS = 28,
    parameter int CW         = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          advance,
    output logic          out_valid,
    output logic          buffering,
    output logic          working,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] pu_addr,
    output logic [CW-1:0] pu_no,
    output logic [CW-1:0] row_no,
    output logic [CW-1:0] round
);

    localparam longint LP_SPAN = longint'(1) << CW;

    if (KERNEL < 1 || NUM_PU < 1 || NUM_ROUNDS < 1 || CW < 1 ||
        longint'(KERNEL) >= LP_SPAN || longint'(NUM_PU) >= LP_SPAN ||
        longint'(NUM_ROUNDS) >= LP_SPAN) begin : g_param_check
        $error("img2col_map_ctrl: invalid parameters (need all >= 1 and 2^CW > max(KERNEL, NUM_PU, NUM_ROUNDS))");
    end

    localparam logic [CW-1:0] LP_K_LAST   = CW'(KERNEL - 1);
    localparam logic [CW-1:0] LP_PU_LAST  = CW'(NUM_PU - 1);
    localparam logic [CW-1:0] LP_RND_LAST = CW'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUFFER,
        S_WORK,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [CW-1:0] r_pu_addr, r_pu_no, r_row_no, r_round;
    logic [CW-1:0] w_pu_addr_nx, w_pu_no_nx, w_row_no_nx, w_round_nx;
    logic          w_slot_end;
    logic          w_row_end;

    assign w_slot_end = (r_pu_addr == LP_K_LAST);
    assign w_row_end  = w_slot_end && (r_pu_no == LP_PU_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pu_addr <= '0;
            r_pu_no   <= '0;
            r_row_no  <= '0;
            r_round   <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_pu_addr <= w_pu_addr_nx;
            r_pu_no   <= w_pu_no_nx;
            r_row_no  <= w_row_no_nx;
            r_round   <= w_round_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_pu_addr_nx = r_pu_addr;
        w_pu_no_nx   = r_pu_no;
        w_row_no_nx  = r_row_no;
        w_round_nx   = r_round;
        if (abort) begin
            w_state_nx   = S_IDLE;
            w_pu_addr_nx = '0;
            w_pu_no_nx   = '0;
            w_row_no_nx  = '0;
            w_round_nx   = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_pu_addr_nx = '0;
                    w_pu_no_nx   = '0;
                    w_row_no_nx  = '0;
                    w_round_nx   = '0;
                    if (start) w_state_nx = S_BUFFER;
                end
                S_BUFFER, S_WORK: begin
                    // The final WORK step moves to DONE without stepping, so the last address stays visible.
                    if (advance) begin
                        if (r_state == S_WORK && w_row_end && r_round == LP_RND_LAST) begin
                            w_state_nx = S_DONE;
                        end else begin
                            w_pu_addr_nx = w_slot_end ? '0 : r_pu_addr + CW'(1);
                            if (w_slot_end) w_pu_no_nx = w_row_end ? '0 : r_pu_no + CW'(1);
                            if (w_row_end) begin
                                if (r_state == S_BUFFER) begin
                                    if (r_row_no == LP_K_LAST) begin
                                        w_state_nx = S_WORK;
                                        w_round_nx = '0;
                                    end else begin
                                        w_row_no_nx = r_row_no + CW'(1);
                                    end
                                end else begin
                                    w_round_nx = r_round + CW'(1);
                                end
                            end
                        end
                    end
                end
                S_DONE: begin
                    w_state_nx   = S_IDLE;
                    w_pu_addr_nx = '0;
                    w_pu_no_nx   = '0;
                    w_row_no_nx  = '0;
                    w_round_nx   = '0;
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    assign out_valid = (r_state == S_BUFFER) || (r_state == S_WORK);
    assign buffering = (r_state == S_BUFFER);
    assign working   = (r_state == S_WORK);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign pu_addr   = r_pu_addr;
    assign pu_no     = r_pu_no;
    assign row_no    = r_row_no;
    assign round     = r_round;

endmodule

// File: tb/tb_img2col_map_ctrl.sv
// Bench for img2col_map_ctrl: three parameterisations share one stimulus stream and are
// compared every cycle against a step-count model, plus literal timing expectations.
module tb_img2col_map_ctrl;

    logic clk, rst, start, abort, advance;

    logic       v0, bf0, wk0, bs0, dn0;
    logic [5:0] pa0, pn0, rn0, rd0;
    logic       v1, bf1, wk1, bs1, dn1;
    logic [2:0] pa1, pn1, rn1, rd1;
    logic       v2, bf2, wk2, bs2, dn2;
    logic [1:0] pa2, pn2, rn2, rd2;

    img2col_map_ctrl #(.KERNEL(5), .NUM_PU(28), .NUM_ROUNDS(28), .CW(6)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .advance(advance),
        .out_valid(v0), .buffering(bf0), .working(wk0), .busy(bs0), .done(dn0),
        .pu_addr(pa0), .pu_no(pn0), .row_no(rn0), .round(rd0));

    img2col_map_ctrl #(.KERNEL(3), .NUM_PU(4), .NUM_ROUNDS(2), .CW(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .advance(advance),
        .out_valid(v1), .buffering(bf1), .working(wk1), .busy(bs1), .done(dn1),
        .pu_addr(pa1), .pu_no(pn1), .row_no(rn1), .round(rd1));

    img2col_map_ctrl #(.KERNEL(1), .NUM_PU(2), .NUM_ROUNDS(3), .CW(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .advance(advance),
        .out_valid(v2), .buffering(bf2), .working(wk2), .busy(bs2), .done(dn2),
        .pu_addr(pa2), .pu_no(pn2), .row_no(rn2), .round(rd2));

    // Observation layout: busy, out_valid, buffering, working, done, pu_addr, pu_no, row_no, round.
    logic [28:0] obs [3];
    assign obs[0] = {bs0, v0, bf0, wk0, dn0, pa0, pn0, rn0, rd0};
    assign obs[1] = {bs1, v1, bf1, wk1, dn1, 3'b0, pa1, 3'b0, pn1, 3'b0, rn1, 3'b0, rd1};
    assign obs[2] = {bs2, v2, bf2, wk2, dn2, 4'b0, pa2, 4'b0, pn2, 4'b0, rn2, 4'b0, rd2};

    int kk [3] = '{5, 3, 1};
    int np [3] = '{28, 4, 2};
    int nr [3] = '{28, 2, 3};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Model: phase 0 idle, 1 active, 2 done; m_steps counts accepted addresses in the sequence.
    int m_phase [3];
    int m_steps [3];

    function automatic int total_steps(input int i);
        return kk[i] * np[i] * kk[i] + nr[i] * np[i] * kk[i];
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst || abort) begin
                m_phase[i] <= 0;
                m_steps[i] <= 0;
            end else begin
                case (m_phase[i])
                    0: if (start) begin
                        m_phase[i] <= 1;
                        m_steps[i] <= 0;
                    end
                    1: if (advance) begin
                        if (m_steps[i] == total_steps(i) - 1) m_phase[i] <= 2;
                        else m_steps[i] <= m_steps[i] + 1;
                    end
                    default: begin
                        m_phase[i] <= 0;
                        m_steps[i] <= 0;
                    end
                endcase
            end
        end
    end

    function automatic logic [28:0] expv(input int i);
        int b, s, w, rowlen;
        logic [5:0] pa, pn, rn, rd;
        pa = '0; pn = '0; rn = '0; rd = '0;
        b = kk[i] * np[i] * kk[i];
        rowlen = kk[i] * np[i];
        s = m_steps[i];
        if (m_phase[i] != 0) begin
            if (s < b) begin
                pa = 6'(s % kk[i]);
                pn = 6'((s / kk[i]) % np[i]);
                rn = 6'(s / rowlen);
            end else begin
                w  = s - b;
                pa = 6'(w % kk[i]);
                pn = 6'((w / kk[i]) % np[i]);
                rn = 6'(kk[i] - 1);
                rd = 6'(w / rowlen);
            end
        end
        return {m_phase[i] != 0, m_phase[i] == 1, m_phase[i] == 1 && s < b,
                m_phase[i] == 1 && s >= b, m_phase[i] == 2, pa, pn, rn, rd};
    endfunction

    logic d2_addr_nonzero = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("model_dut%0d", i), 32'(obs[i]), 32'(expv(i)));
        end
        if (pa2 != 2'd0) d2_addr_nonzero = 1'b1;
    end

    int r_done [3];
    int r_buf  [3];
    int r_work [3];
    int r_stalls;
    logic r_busy_after, r_buf_after;
    logic [28:0] snap [3];

    // mode 0: advance=1; 1: random advance; 2: start noise mid-run; 3: start held high.
    task automatic run_seq(input int mode);
        int cyc;
        for (int i = 0; i < 3; i++) begin
            r_done[i] = 0; r_buf[i] = 0; r_work[i] = 0;
        end
        r_stalls = 0; r_busy_after = 1'b1; r_buf_after = 1'b0;
        for (int i = 0; i < 3; i++) snap[i] = '0;
        start = 1; advance = 1;
        @(posedge clk); #2;
        if (mode != 3) start = 0;
        advance = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        cyc = 0;
        while (cyc < 12000) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (r_done[i] == 0) begin
                    if (obs[i][26]) r_buf[i]++;
                    if (obs[i][25]) r_work[i]++;
                    if (obs[i][24]) r_done[i] = cyc;
                end
            end
            if (obs[0][27] && !advance) r_stalls++;
            if (cyc == 701)  snap[0] = obs[0];
            if (cyc == 4620) snap[1] = obs[0];
            if (cyc == 4621) snap[2] = obs[0];
            if (r_done[0] != 0 && cyc == r_done[0] + 1) r_busy_after = obs[0][28];
            if (r_done[0] != 0 && cyc == r_done[0] + 2) begin
                r_buf_after = obs[0][26];
                break;
            end
            @(posedge clk); #2;
            advance = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mode == 2) start = (cyc > 800 && cyc < 4000) ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        if (r_done[0] == 0) $display("FAIL run_timeout mode=%0d actual=no_done required=done", mode);
        @(posedge clk); #2;
        start = 0; advance = 1;
    endtask

    int dcount;

    initial begin
        rst = 1; start = 0; abort = 0; advance = 0;
        #3;
        for (int i = 0; i < 3; i++) check($sformatf("reset_state%0d", i), 32'(obs[i]), 32'h0);
        #19 rst = 0;
        repeat (2) @(negedge clk);

        run_seq(0);
        check("d0_done_cycle", r_done[0], 4621);
        check("d0_buffer_len", r_buf[0], 700);
        check("d0_work_len", r_work[0], 3920);
        check("d0_busy_after_done", 32'(r_busy_after), 32'h0);
        check("d0_first_work", 32'(snap[0]), 32'({5'b11010, 6'd0, 6'd0, 6'd4, 6'd0}));
        check("d0_last_work", 32'(snap[1]), 32'({5'b11010, 6'd4, 6'd27, 6'd4, 6'd27}));
        check("d0_done_state", 32'(snap[2]), 32'({5'b10001, 6'd4, 6'd27, 6'd4, 6'd27}));
        check("d1_done_cycle", r_done[1], 61);
        check("d1_buffer_len", r_buf[1], 36);
        check("d1_work_len", r_work[1], 24);
        check("d2_done_cycle", r_done[2], 9);
        check("d2_buffer_len", r_buf[2], 2);
        check("d2_work_len", r_work[2], 6);
        repeat (3) @(negedge clk);

        run_seq(1);
        check("stall_done_cycle", r_done[0], 4621 + r_stalls);
        repeat (3) @(negedge clk);

        // Abort while D0 presents BUFFER step 137.
        @(posedge clk); #2 start = 1; advance = 1;
        @(posedge clk); #2 start = 0;
        repeat (137) @(negedge clk);
        @(posedge clk); #2 abort = 1;
        @(negedge clk);
        check("abort_step137_addr", 32'(obs[0]), 32'({5'b11100, 6'd2, 6'd27, 6'd0, 6'd0}));
        @(posedge clk); #2 abort = 0;
        @(negedge clk);
        check("abort_idle", 32'(obs[0]), 32'h0);
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (dn0) dcount++;
        end
        check("abort_no_done", dcount, 0);

        @(posedge clk); #2 start = 1; abort = 1;
        @(posedge clk); #2 start = 0; abort = 0;
        @(negedge clk);
        check("abort_beats_start", 32'(bs0), 32'h0);
        repeat (2) @(negedge clk);

        run_seq(2);
        check("restart_noise_done_cycle", r_done[0], 4621);
        check("restart_noise_work_len", r_work[0], 3920);
        repeat (3) @(negedge clk);

        run_seq(3);
        check("hold_done_cycle", r_done[0], 4621);
        check("hold_idle_gap", 32'(r_busy_after), 32'h0);
        check("hold_rebuffer", 32'(r_buf_after), 32'h1);
        @(posedge clk); #2 abort = 1;
        @(posedge clk); #2 abort = 0;
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-WORK.
        @(posedge clk); #2 start = 1;
        @(posedge clk); #2 start = 0;
        repeat (1000) @(negedge clk);
        check("pre_reset_working", 32'(wk0), 32'h1);
        @(posedge clk); #3 rst = 1;
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("async_reset%0d", i), 32'(obs[i]), 32'h0);
        repeat (2) @(posedge clk);
        #2 rst = 0;
        repeat (5) @(negedge clk);
        check("post_reset_idle", 32'(obs[0]), 32'h0);

        check("d2_pu_addr_zero", 32'(d2_addr_nonzero), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/img2col_map_ctrl.md
# img2col_map_ctrl

Parametrised sequencer for the img2col mapping stage. It generates the processing-unit (PU) write-address schedule: a buffering phase preloads KERNEL image rows into NUM_PU PUs, and a working phase streams NUM_ROUNDS further rows. It adds three things to the fixed 5×28 controller: a per-step `advance` stall, a synchronous `abort`, and `busy`/`done` status. It sits between the top-level convolution sequencer (`start`, `abort`, `done`) and the img2col PU array and line-buffer read logic (address outputs, `advance`).

## Interface
Parameters:
- KERNEL, 5, kernel height/width; address slots per PU, and rows preloaded in buffering.
- NUM_PU, 28, PUs per row.
- NUM_ROUNDS, 28, rows streamed in the working phase.
- CW, 6, counter/output width. Elaboration error unless 2^CW > max(KERNEL, NUM_PU, NUM_ROUNDS); all parameters ≥ 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a map sequence; sampled only in IDLE.
- abort  in  1  synchronous cancel; highest priority.
- advance  in  1  consumer accepts the current address; the step happens when out_valid & advance.
- out_valid  out  1  high in BUFFER and WORK.
- buffering  out  1  high in BUFFER.
- working  out  1  high in WORK.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse in DONE.
- pu_addr  out  CW  slot within the PU, range 0..KERNEL-1.
- pu_no  out  CW  PU index, range 0..NUM_PU-1.
- row_no  out  CW  preload row index, range 0..KERNEL-1.
- round  out  CW  working round, range 0..NUM_ROUNDS-1.

## Operation
- States: IDLE, BUFFER, WORK, DONE. All outputs are registered (derived from state and counter flops).
- Reset: the block enters IDLE and every output is 0.
- IDLE:
  - All counters are held at 0.
  - start=1 and abort=0 → BUFFER.
- Step (only when out_valid=1 and advance=1):
  - pu_addr increments.
  - At pu_addr=KERNEL-1, pu_addr wraps to 0 and pu_no increments.
  - At pu_no=NUM_PU-1 with pu_addr=KERNEL-1 (row end), pu_no wraps to 0.
- Row end in BUFFER:
  - row_no<KERNEL-1 → row_no+1.
  - row_no=KERNEL-1 → WORK, with round=0 and row_no held at KERNEL-1.
- Row end in WORK:
  - round<NUM_ROUNDS-1 → round+1.
  - round=NUM_ROUNDS-1 → DONE. Counters hold their final values.
- DONE: lasts exactly one cycle with done=1, then IDLE, where counters clear to 0.
- advance=0: all counters and the state hold, and outputs stay stable. There is no timeout.
- abort=1, in any state:
  - The next state is IDLE and all counters clear.
  - done is not pulsed.
  - abort beats start and advance in the same cycle.
- start outside IDLE is ignored, and there is no queueing. start held high through DONE→IDLE restarts the sequence one cycle after IDLE is entered.
- Degenerate KERNEL=1: pu_addr is constantly 0 and BUFFER is one row.
- Counters never exceed their ranges; no modulo-2^CW wrap can occur.

## Timing
- Latency: start sampled at edge E0 → busy, buffering and out_valid are high after E0. The first address (0,0,0,0) is valid in the cycle following E0.
- Address hold: each address is presented for at least one cycle and changes only on the edge where it is accepted with advance=1.
- Length with advance held at 1:
  - BUFFER lasts KERNEL·NUM_PU·KERNEL cycles.
  - WORK lasts NUM_ROUNDS·NUM_PU·KERNEL cycles.
  - DONE lasts 1 cycle.
  - Defaults: 700 + 3920 + 1. done is high in the 4621st cycle after E0.
- Phase transitions:
  - BUFFER→WORK: the cycle after the last BUFFER step shows working=1, pu_addr=0, pu_no=0, round=0.
  - WORK→DONE: out_valid drops to 0 on the same edge that raises done.
- Stall overhead: each cycle with advance=0 lengthens the sequence by exactly one cycle.
- Asynchronous reset: asserting rst mid-operation forces all outputs to 0 immediately. Deassertion is synchronised externally.

## Test plan
- Reset: rst pulse mid-WORK → all outputs 0 without waiting for a clock edge; the block stays in IDLE with start=0.
- Default full run, advance=1: start at cycle 0 → buffering=1 for 700 cycles, working=1 for 3920 cycles, done=1 exactly once at cycle 4621, and busy falls the following cycle. Scoreboard checks that the address tuple sequence is lexicographic.
- Stall: advance toggled randomly (50%) → sequence identical to the full-run sequence, with total cycles equal to 4620 plus the number of advance=0 cycles in BUFFER/WORK.
- Abort:
  - abort at BUFFER step 137 → IDLE next cycle, all counters 0, no done.
  - Re-start → full run completes.
  - abort and start together in IDLE → stays in IDLE.
- Boundary: check row_no=4 → WORK transition at step 700, and round=27 → DONE. start pulses during WORK have no effect. start held high → a new BUFFER begins one cycle after DONE→IDLE.
- Alternate parameters KERNEL=3, NUM_PU=4, NUM_ROUNDS=2, CW=3 → BUFFER 36 cycles, WORK 24 cycles, done at cycle 61. Also check KERNEL=1 → pu_addr is always 0.
